avg8_sample_loader: RTL

//  Upstream feeder for the HLSM 8-input averaging core. Collects 8 samples from a

---
 rtl/avg_loader_pkg.sv | 14 +
 rtl/avg8_sample_loader.sv | 120 ++++++++++++
 2 files changed

// File: rtl/avg_loader_pkg.sv
// Shared types and sizes for the 8-sample averaging-core loader.
package avg_loader_pkg;

   localparam int unsigned NUM_SAMPLES = 8;
   localparam int unsigned CNT_W       = 3;

   typedef enum logic [1:0] {
      FILL      = 2'd0,
      START     = 2'd1,
      WAIT_DONE = 2'd2,
      OUT       = 2'd3
   } state_t;

endpackage

// File: rtl/avg8_sample_loader.sv
// Collects 8 streamed samples, kicks the averaging core and returns its result.
// Optional core-done watchdog enabled by defining AVG_LOADER_TIMEOUT_EN.
module avg8_sample_loader
   import avg_loader_pkg::*;
#(
   parameter int unsigned DATA_W         = 32,
   parameter int unsigned SHIFT_AMT      = 1,
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic              Clk,
   input  logic              Rst,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_ready,
   output logic              core_start,
   input  logic              core_done,
   input  logic [DATA_W-1:0] core_avg,
   output logic [DATA_W-1:0] core_a,
   output logic [DATA_W-1:0] core_b,
   output logic [DATA_W-1:0] core_c,
   output logic [DATA_W-1:0] core_d,
   output logic [DATA_W-1:0] core_e,
   output logic [DATA_W-1:0] core_f,
   output logic [DATA_W-1:0] core_g,
   output logic [DATA_W-1:0] core_h,
   output logic [DATA_W-1:0] core_sa,
   output logic              res_valid,
   output logic [DATA_W-1:0] res_data,
   input  logic              res_ready,
   output logic              res_err
);

   state_t              state;
   logic [CNT_W-1:0]    count;
   logic [DATA_W-1:0]   slots [NUM_SAMPLES];

`ifdef AVG_LOADER_TIMEOUT_EN
   localparam int unsigned WAIT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [WAIT_W-1:0]   wait_cnt;
`endif

   // Slots only change during FILL, so the core sees frozen operands while it works.
   always_ff @(posedge Clk or negedge Rst) begin
      if (!Rst) begin
         state      <= FILL;
         count      <= '0;
         in_ready   <= 1'b0;
         core_start <= 1'b0;
         res_valid  <= 1'b0;
         res_data   <= '0;
         for (int i = 0; i < NUM_SAMPLES; i++) slots[i] <= '0;
`ifdef AVG_LOADER_TIMEOUT_EN
         res_err    <= 1'b0;
         wait_cnt   <= '0;
`endif
      end else begin
         core_start <= 1'b0;
         case (state)
            FILL: begin
               in_ready <= 1'b1;
               if (in_valid && in_ready) begin
                  slots[count] <= in_data;
                  count        <= count + CNT_W'(1);
                  if (count == CNT_W'(NUM_SAMPLES - 1)) begin
                     state      <= START;
                     in_ready   <= 1'b0;
                     core_start <= 1'b1;
                  end
               end
            end
            START: begin
               state <= WAIT_DONE;
`ifdef AVG_LOADER_TIMEOUT_EN
               wait_cnt <= '0;
`endif
            end
            WAIT_DONE: begin
               if (core_done) begin
                  res_data  <= core_avg;
                  res_valid <= 1'b1;
                  state     <= OUT;
`ifdef AVG_LOADER_TIMEOUT_EN
                  res_err   <= 1'b0;
               end else if (wait_cnt == WAIT_W'(TIMEOUT_CYCLES - 1)) begin
                  res_data  <= '0;
                  res_err   <= 1'b1;
                  res_valid <= 1'b1;
                  state     <= OUT;
               end else begin
                  wait_cnt  <= wait_cnt + WAIT_W'(1);
`endif
               end
            end
            OUT: begin
               if (res_ready) begin
                  res_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= FILL;
               end
            end
            default: state <= FILL;
         endcase
      end
   end

`ifndef AVG_LOADER_TIMEOUT_EN
   assign res_err = 1'b0;
`endif

   assign core_a  = slots[0];
   assign core_b  = slots[1];
   assign core_c  = slots[2];
   assign core_d  = slots[3];
   assign core_e  = slots[4];
   assign core_f  = slots[5];
   assign core_g  = slots[6];
   assign core_h  = slots[7];
   assign core_sa = DATA_W'(SHIFT_AMT);

endmodule
